// File: rtl/decode_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : decode_issue_queue (with decode_issue_pkg and mips_decoder)
// Purpose  : Circular fetch buffer with per-slot MIPS decode and in-order
//            issue-group formation (delay-slot pairing, serialising ops, RAW).
// Revision : 1.0 - initial release
// ============================================================================
package decode_issue_pkg;
  typedef logic [31:0] instr_t;

  typedef enum logic [4:0] {
    OP_SLL, OP_JR, OP_SYSCALL, OP_BREAK, OP_MFHI, OP_MFLO, OP_MULT, OP_MULTU,
    OP_DIV, OP_DIVU, OP_ADDU, OP_SUBU, OP_AND, OP_OR, OP_SLT, OP_BEQ, OP_BNE,
    OP_J, OP_JAL, OP_ADDIU, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_MFC0, OP_MTC0,
    OP_ERET, OP_INVALID
  } op_t;

  typedef struct packed {
    logic branch;
    logic jump;
    logic is_multdiv;
    logic cp0write;
    logic is_eret;
    logic is_sys;
    logic is_bp;
    logic exception_ri;
    logic regwrite;
    logic memread;
    logic memwrite;
  } ctl_t;

  typedef struct packed {
    op_t         op;
    ctl_t        ctl;
    logic [4:0]  srca;
    logic [4:0]  srcb;
    logic [4:0]  dest;
    logic [31:0] imm;
    logic [31:0] pcplus4;
  } decoded_instr_t;
endpackage

module mips_decoder
  import decode_issue_pkg::*;
(
  input  instr_t         instr,
  input  logic [31:0]    pcplus4,
  output decoded_instr_t dec
);
  logic [5:0] w_opcode, w_funct;
  logic [4:0] w_rs, w_rt, w_rd;

  assign w_opcode = instr[31:26];
  assign w_rs     = instr[25:21];
  assign w_rt     = instr[20:16];
  assign w_rd     = instr[15:11];
  assign w_funct  = instr[5:0];

  always_comb begin
    dec         = '0;
    dec.op      = OP_INVALID;
    dec.pcplus4 = pcplus4;
    dec.imm     = {{16{instr[15]}}, instr[15:0]};
    dec.srca    = w_rs;
    dec.srcb    = w_rt;
    case (w_opcode)
      6'h00: begin
        case (w_funct)
          6'h00: begin dec.op = OP_SLL; dec.srca = '0; dec.dest = w_rd; dec.ctl.regwrite = 1'b1;
                       dec.imm = {27'd0, instr[10:6]}; end
          6'h08: begin dec.op = OP_JR; dec.srcb = '0; dec.ctl.jump = 1'b1; end
          6'h0c: begin dec.op = OP_SYSCALL; dec.ctl.is_sys = 1'b1; end
          6'h0d: begin dec.op = OP_BREAK; dec.ctl.is_bp = 1'b1; end
          6'h10, 6'h12: begin
            dec.op = (w_funct == 6'h10) ? OP_MFHI : OP_MFLO;
            dec.srca = '0; dec.srcb = '0; dec.dest = w_rd; dec.ctl.regwrite = 1'b1;
          end
          6'h18, 6'h19, 6'h1a, 6'h1b: begin
            case (w_funct[1:0])
              2'd0:    dec.op = OP_MULT;
              2'd1:    dec.op = OP_MULTU;
              2'd2:    dec.op = OP_DIV;
              default: dec.op = OP_DIVU;
            endcase
            dec.ctl.is_multdiv = 1'b1;
          end
          6'h21, 6'h23, 6'h24, 6'h25, 6'h2a: begin
            case (w_funct)
              6'h21:   dec.op = OP_ADDU;
              6'h23:   dec.op = OP_SUBU;
              6'h24:   dec.op = OP_AND;
              6'h25:   dec.op = OP_OR;
              default: dec.op = OP_SLT;
            endcase
            dec.dest = w_rd; dec.ctl.regwrite = 1'b1;
          end
          default: dec.ctl.exception_ri = 1'b1;
        endcase
      end
      6'h02: begin dec.op = OP_J; dec.srca = '0; dec.srcb = '0; dec.ctl.jump = 1'b1; end
      6'h03: begin dec.op = OP_JAL; dec.srca = '0; dec.srcb = '0; dec.ctl.jump = 1'b1;
                   dec.dest = 5'd31; dec.ctl.regwrite = 1'b1; end
      6'h04: begin dec.op = OP_BEQ; dec.ctl.branch = 1'b1; end
      6'h05: begin dec.op = OP_BNE; dec.ctl.branch = 1'b1; end
      6'h09: begin dec.op = OP_ADDIU; dec.srcb = '0; dec.dest = w_rt; dec.ctl.regwrite = 1'b1; end
      6'h0d: begin dec.op = OP_ORI; dec.srcb = '0; dec.dest = w_rt; dec.ctl.regwrite = 1'b1;
                   dec.imm = {16'd0, instr[15:0]}; end
      6'h0f: begin dec.op = OP_LUI; dec.srca = '0; dec.srcb = '0; dec.dest = w_rt;
                   dec.ctl.regwrite = 1'b1; dec.imm = {instr[15:0], 16'd0}; end
      6'h23: begin dec.op = OP_LW; dec.srcb = '0; dec.dest = w_rt; dec.ctl.regwrite = 1'b1;
                   dec.ctl.memread = 1'b1; end
      6'h2b: begin dec.op = OP_SW; dec.ctl.memwrite = 1'b1; end
      6'h10: begin
        if (w_rs == 5'h00) begin
          dec.op = OP_MFC0; dec.srca = '0; dec.srcb = '0; dec.dest = w_rt; dec.ctl.regwrite = 1'b1;
        end else if (w_rs == 5'h04) begin
          dec.op = OP_MTC0; dec.srca = '0; dec.ctl.cp0write = 1'b1;
        end else if (instr[25] && (w_funct == 6'h18)) begin
          dec.op = OP_ERET; dec.srca = '0; dec.srcb = '0; dec.ctl.is_eret = 1'b1;
        end else begin
          dec.ctl.exception_ri = 1'b1;
        end
      end
      default: dec.ctl.exception_ri = 1'b1;
    endcase
  end
endmodule

module decode_issue_queue
  import decode_issue_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic                                 in_valid,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0]     in_count,
  input  instr_t [FETCH_WIDTH-1:0]             in_instr,
  input  logic [FETCH_WIDTH-1:0][31:0]         in_pc,
  output logic                                 in_ready,
  output logic [ISSUE_WIDTH-1:0]               out_valid,
  output decoded_instr_t [ISSUE_WIDTH-1:0]     out_instr,
  output logic [ISSUE_WIDTH-1:0][31:0]         out_pc,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]     out_take,
  output logic [$clog2(DEPTH+1)-1:0]           count
);
  localparam int c_ptr_w  = $clog2(DEPTH);
  localparam int c_cnt_w  = $clog2(DEPTH+1);
  localparam int c_take_w = $clog2(ISSUE_WIDTH+1);

  instr_t              r_instr_mem [DEPTH];
  logic [31:0]         r_pc_mem    [DEPTH];
  logic [c_ptr_w-1:0]  r_rd_ptr, r_wr_ptr;
  logic [c_cnt_w-1:0]  r_count;
  logic                w_enq;
  logic [c_ptr_w-1:0]  w_wr_idx [FETCH_WIDTH];
  decoded_instr_t      w_dec    [ISSUE_WIDTH];
  logic [ISSUE_WIDTH-1:0] w_valid;
  logic [c_take_w-1:0] w_nvalid;

  assign in_ready  = (r_count <= c_cnt_w'(DEPTH - FETCH_WIDTH));
  assign w_enq     = in_valid && in_ready && (in_count != '0) && !flush && !reset;
  assign out_valid = w_valid;
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + c_ptr_w'(out_take);
      if (w_enq) r_wr_ptr <= r_wr_ptr + c_ptr_w'(in_count);
      r_count  <= r_count + (w_enq ? c_cnt_w'(in_count) : c_cnt_w'(0)) - c_cnt_w'(out_take);
    end
  end

  for (genvar l = 0; l < FETCH_WIDTH; l++) begin : g_lane
    assign w_wr_idx[l] = r_wr_ptr + c_ptr_w'(l);
  end

  // Payload storage carries no reset; only the pointers define what is live.
  always_ff @(posedge clk) begin
    for (int l = 0; l < FETCH_WIDTH; l++) begin
      if (w_enq && (l < int'(in_count))) begin
        r_instr_mem[w_wr_idx[l]] <= in_instr[l];
        r_pc_mem[w_wr_idx[l]]    <= in_pc[l];
      end
    end
  end

  for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_slot
    logic [c_ptr_w-1:0] w_rd_idx;
    assign w_rd_idx     = r_rd_ptr + c_ptr_w'(k);
    assign out_pc[k]    = r_pc_mem[w_rd_idx];
    assign out_instr[k] = w_dec[k];
    mips_decoder u_dec (
      .instr   (r_instr_mem[w_rd_idx]),
      .pcplus4 (r_pc_mem[w_rd_idx] + 32'd4),
      .dec     (w_dec[k])
    );
  end

  // Walk slots oldest first; a slot following a branch is its delay slot and
  // rides with it unconditionally, everything else must pass the group rules.
  always_comb begin
    logic stop, ds_pending, hazard, serial;
    w_valid    = '0;
    w_nvalid   = '0;
    stop       = 1'b0;
    ds_pending = 1'b0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      serial = w_dec[k].ctl.is_multdiv | w_dec[k].ctl.cp0write | w_dec[k].ctl.is_eret |
               w_dec[k].ctl.is_sys | w_dec[k].ctl.is_bp | w_dec[k].ctl.exception_ri;
      hazard = 1'b0;
      for (int j = 0; j < k; j++) begin
        if (w_dec[j].ctl.regwrite && (w_dec[j].dest != '0) &&
            ((w_dec[k].srca == w_dec[j].dest) || (w_dec[k].srcb == w_dec[j].dest)))
          hazard = 1'b1;
      end
      if (!stop && (c_cnt_w'(k) < r_count)) begin
        if (ds_pending) begin
          w_valid[k] = 1'b1;
          ds_pending = 1'b0;
          stop       = serial;
        end else if (serial) begin
          w_valid[k] = (k == 0);
          stop       = 1'b1;
        end else if (hazard) begin
          stop = 1'b1;
        end else if (w_dec[k].ctl.branch || w_dec[k].ctl.jump) begin
          if ((k + 1 < ISSUE_WIDTH) && (c_cnt_w'(k + 1) < r_count)) begin
            w_valid[k] = 1'b1;
            ds_pending = 1'b1;
          end else begin
            stop = 1'b1;
          end
        end else begin
          w_valid[k] = 1'b1;
        end
      end else begin
        stop = 1'b1;
      end
      if (w_valid[k]) w_nvalid = w_nvalid + 1'b1;
    end
  end

  a_take_legal: assert property (@(posedge clk) disable iff (reset) (out_take <= w_nvalid));
endmodule
`default_nettype wire

// File: tb/tb_decode_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_issue_queue
// Purpose  : Directed scenarios plus random traffic against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_issue_queue;
  import decode_issue_pkg::*;

  localparam int FW = 2, IW = 2, DEPTH = 8;
  localparam int K_ADDU = 0, K_SUBU = 1, K_OR = 2, K_ADDIU = 3, K_LW = 4, K_SW = 5,
                 K_BEQ = 6, K_BNE = 7, K_J = 8, K_JAL = 9, K_JR = 10, K_MULT = 11,
                 K_DIV = 12, K_SYSCALL = 13, K_BREAK = 14, K_MTC0 = 15, K_ERET = 16,
                 K_RI = 17;

  typedef struct {
    int          kind;
    logic [4:0]  rs, rt, rd;
    logic [31:0] pc;
  } ent_t;

  logic clk = 1'b0;
  logic reset, flush, in_valid, in_ready;
  logic [$clog2(FW+1)-1:0]    in_count;
  instr_t [FW-1:0]            in_instr;
  logic [FW-1:0][31:0]        in_pc;
  logic [IW-1:0]              out_valid;
  decoded_instr_t [IW-1:0]    out_instr;
  logic [IW-1:0][31:0]        out_pc;
  logic [$clog2(IW+1)-1:0]    out_take;
  logic [$clog2(DEPTH+1)-1:0] count;

  always #5 clk = ~clk;

  decode_issue_queue #(.FETCH_WIDTH(FW), .ISSUE_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_count(in_count),
    .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready), .out_valid(out_valid),
    .out_instr(out_instr), .out_pc(out_pc), .out_take(out_take), .count(count)
  );

  ent_t q[$];
  ent_t lane[FW];
  int   checks = 0, failures = 0;
  bit   last_acc, last_kill;
  logic [31:0] pc_ctr = 32'h1000;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  function automatic logic [31:0] encode(ent_t e);
    case (e.kind)
      K_ADDU:    return {6'h00, e.rs, e.rt, e.rd, 5'h00, 6'h21};
      K_SUBU:    return {6'h00, e.rs, e.rt, e.rd, 5'h00, 6'h23};
      K_OR:      return {6'h00, e.rs, e.rt, e.rd, 5'h00, 6'h25};
      K_ADDIU:   return {6'h09, e.rs, e.rt, 16'h0010};
      K_LW:      return {6'h23, e.rs, e.rt, 16'h0004};
      K_SW:      return {6'h2b, e.rs, e.rt, 16'h0008};
      K_BEQ:     return {6'h04, e.rs, e.rt, 16'h0003};
      K_BNE:     return {6'h05, e.rs, e.rt, 16'h0003};
      K_J:       return {6'h02, 26'h0000040};
      K_JAL:     return {6'h03, 26'h0000040};
      K_JR:      return {6'h00, e.rs, 15'h0000, 6'h08};
      K_MULT:    return {6'h00, e.rs, e.rt, 10'h000, 6'h18};
      K_DIV:     return {6'h00, e.rs, e.rt, 10'h000, 6'h1a};
      K_SYSCALL: return 32'h0000000c;
      K_BREAK:   return 32'h0000000d;
      K_MTC0:    return {6'h10, 5'h04, e.rt, e.rd, 11'h000};
      K_ERET:    return 32'h42000018;
      default:   return {6'h3f, 26'h0};
    endcase
  endfunction

  function automatic op_t exp_op(int kind);
    case (kind)
      K_ADDU: return OP_ADDU;    K_SUBU: return OP_SUBU;   K_OR: return OP_OR;
      K_ADDIU: return OP_ADDIU;  K_LW: return OP_LW;       K_SW: return OP_SW;
      K_BEQ: return OP_BEQ;      K_BNE: return OP_BNE;     K_J: return OP_J;
      K_JAL: return OP_JAL;      K_JR: return OP_JR;       K_MULT: return OP_MULT;
      K_DIV: return OP_DIV;      K_SYSCALL: return OP_SYSCALL;
      K_BREAK: return OP_BREAK;  K_MTC0: return OP_MTC0;   K_ERET: return OP_ERET;
      default: return OP_INVALID;
    endcase
  endfunction

  function automatic bit is_branch(int kind);
    return kind inside {K_BEQ, K_BNE, K_J, K_JAL, K_JR};
  endfunction

  function automatic bit is_serial(int kind);
    return kind inside {K_MULT, K_DIV, K_SYSCALL, K_BREAK, K_MTC0, K_ERET, K_RI};
  endfunction

  function automatic logic [4:0] dest_of(ent_t e);
    if (e.kind inside {K_ADDU, K_SUBU, K_OR}) return e.rd;
    if (e.kind inside {K_ADDIU, K_LW})        return e.rt;
    if (e.kind == K_JAL)                      return 5'd31;
    return 5'd0;
  endfunction

  function automatic bit reads_reg(ent_t e, logic [4:0] r);
    bit rs_used = e.kind inside {K_ADDU, K_SUBU, K_OR, K_ADDIU, K_LW, K_SW, K_BEQ, K_BNE, K_JR};
    bit rt_used = e.kind inside {K_ADDU, K_SUBU, K_OR, K_SW, K_BEQ, K_BNE};
    return (r != 5'd0) && ((rs_used && e.rs == r) || (rt_used && e.rt == r));
  endfunction

  // Length of the issuable prefix of the model queue.
  function automatic int group_len();
    int avail = (q.size() < IW) ? q.size() : IW;
    int n = 0;
    int k = 0;
    while (k < avail) begin
      bit hz = 0;
      if (is_serial(q[k].kind)) begin
        if (k == 0) n = 1;
        break;
      end
      for (int j = 0; j < k; j++) if (reads_reg(q[k], dest_of(q[j]))) hz = 1;
      if (hz) break;
      if (is_branch(q[k].kind)) begin
        if (k + 1 < avail) begin
          n = k + 2;
          if (is_serial(q[k+1].kind)) break;
          k += 2;
        end else break;
      end else begin
        n = k + 1;
        k++;
      end
    end
    return n;
  endfunction

  task automatic check_outputs();
    int n = group_len();
    chk("count", 64'(count), 64'(q.size()));
    chk("in_ready", 64'(in_ready), 64'((DEPTH - q.size()) >= FW));
    chk("out_valid", 64'(out_valid), 64'((1 << n) - 1));
    for (int k = 0; k < n; k++) begin
      chk($sformatf("pc[%0d]", k), 64'(out_pc[k]), 64'(q[k].pc));
      chk($sformatf("op[%0d]", k), 64'(out_instr[k].op), 64'(exp_op(q[k].kind)));
      chk($sformatf("pcplus4[%0d]", k), 64'(out_instr[k].pcplus4), 64'(q[k].pc + 32'd4));
    end
  endtask

  task automatic cycle();
    int  sz;
    bit  acc;
    @(posedge clk);
    sz  = q.size();
    acc = in_valid && ((DEPTH - sz) >= FW) && (in_count != 0) && !flush && !reset;
    if (reset || flush) q.delete();
    else begin
      for (int i = 0; i < int'(out_take); i++) if (q.size() > 0) void'(q.pop_front());
      if (acc) for (int l = 0; l < int'(in_count); l++) q.push_back(lane[l]);
    end
    last_acc  = acc;
    last_kill = reset || flush;
    #1;
    check_outputs();
  endtask

  task automatic set_lane(int l, int kind, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                          logic [31:0] pc);
    lane[l]     = '{kind: kind, rs: rs, rt: rt, rd: rd, pc: pc};
    in_instr[l] = encode(lane[l]);
    in_pc[l]    = pc;
  endtask

  task automatic rand_lane(int l);
    int kind = ($urandom_range(0, 1) == 0) ? $urandom_range(K_ADDU, K_SW) : $urandom_range(0, K_RI);
    set_lane(l, kind, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), pc_ctr);
    pc_ctr += 32'd4;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_count = '0; out_take = '0;
    for (int l = 0; l < FW; l++) set_lane(l, K_ADDU, 5'd0, 5'd0, 5'd0, 32'h0);
    cycle();
    cycle();
    reset = 1'b0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);

    // addu/or pair issues together one cycle after enqueue
    set_lane(0, K_ADDU, 5'd1, 5'd2, 5'd3, 32'h100);
    set_lane(1, K_OR,   5'd4, 5'd4, 5'd5, 32'h104);
    in_count = 2'd2; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("t1_valid", 64'(out_valid), 64'h3);
    chk("t1_op0", 64'(out_instr[0].op), 64'(OP_ADDU));
    chk("t1_op1", 64'(out_instr[1].op), 64'(OP_OR));
    chk("t1_pc0", 64'(out_pc[0]), 64'h100);
    chk("t1_pc1", 64'(out_pc[1]), 64'h104);
    out_take = 2'd2;
    cycle();
    out_take = '0;
    chk("t1_drain", 64'(count), 64'd0);

    // branch waits for its delay slot
    set_lane(0, K_BEQ, 5'd1, 5'd2, 5'd0, 32'h200);
    in_count = 2'd1; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("t2_wait0", 64'(out_valid), 64'h0);
    cycle();
    chk("t2_wait1", 64'(out_valid), 64'h0);
    set_lane(0, K_ADDU, 5'd1, 5'd1, 5'd7, 32'h204);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("t2_pair", 64'(out_valid), 64'h3);
    chk("t2_op0", 64'(out_instr[0].op), 64'(OP_BEQ));
    out_take = 2'd2;
    cycle();
    out_take = '0;

    // RAW on $3 splits the group
    set_lane(0, K_ADDU, 5'd1, 5'd2, 5'd3, 32'h300);
    set_lane(1, K_SUBU, 5'd3, 5'd1, 5'd6, 32'h304);
    in_count = 2'd2; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("t3_raw", 64'(out_valid), 64'h1);
    out_take = 2'd1;
    cycle();
    out_take = '0;
    chk("t3_next", 64'(out_valid), 64'h1);
    chk("t3_op0", 64'(out_instr[0].op), 64'(OP_SUBU));
    chk("t3_pc0", 64'(out_pc[0]), 64'h304);
    out_take = 2'd1;
    cycle();

    // serialising mult issues alone
    out_take = '0;
    set_lane(0, K_MULT, 5'd1, 5'd2, 5'd0, 32'h400);
    set_lane(1, K_ADDU, 5'd1, 5'd2, 5'd8, 32'h404);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("t4_mult", 64'(out_valid), 64'h1);
    chk("t4_op0", 64'(out_instr[0].op), 64'(OP_MULT));
    out_take = 2'd1;
    cycle();
    chk("t4_addu", 64'(out_instr[0].op), 64'(OP_ADDU));
    cycle();
    out_take = '0;

    // fill to full, then a held bundle enters once space frees (with wrap)
    for (int b = 0; b < 4; b++) begin
      set_lane(0, K_ADDU, 5'd1, 5'd2, 5'(9 + 2*b), 32'h500 + 32'(8*b));
      set_lane(1, K_ADDU, 5'd1, 5'd2, 5'(10 + 2*b), 32'h504 + 32'(8*b));
      in_valid = 1'b1;
      cycle();
    end
    chk("t5_full", 64'(count), 64'd8);
    chk("t5_notready", 64'(in_ready), 64'd0);
    set_lane(0, K_ADDU, 5'd1, 5'd2, 5'd17, 32'h520);
    set_lane(1, K_ADDU, 5'd1, 5'd2, 5'd18, 32'h524);
    out_take = 2'd2;
    cycle();
    out_take = '0;
    chk("t5_count6", 64'(count), 64'd6);
    chk("t5_ready", 64'(in_ready), 64'd1);
    cycle();
    in_valid = 1'b0;
    chk("t5_refill", 64'(count), 64'd8);
    for (int i = 0; i < 6; i++) begin
      out_take = 2'(group_len());
      cycle();
    end
    out_take = '0;
    chk("t5_empty", 64'(count), 64'd0);

    // flush beats same-cycle enqueue and take
    set_lane(0, K_OR, 5'd1, 5'd1, 5'd2, 32'h600);
    set_lane(1, K_OR, 5'd1, 5'd1, 5'd3, 32'h604);
    in_valid = 1'b1;
    cycle();
    set_lane(0, K_OR, 5'd1, 5'd1, 5'd2, 32'h700);
    set_lane(1, K_OR, 5'd1, 5'd1, 5'd3, 32'h704);
    flush = 1'b1; out_take = 2'd1;
    cycle();
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_valid", 64'(out_valid), 64'd0);
    flush = 1'b0; out_take = '0; in_valid = 1'b0;
    cycle();
    chk("t6_dropped", 64'(count), 64'd0);

    // random traffic
    last_acc = 1'b0; last_kill = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      bit hold = in_valid && (in_count != 0) && !last_acc && !last_kill;
      out_take = 2'($urandom_range(0, group_len()));
      flush    = ($urandom_range(0, 39) == 0);
      reset    = ($urandom_range(0, 299) == 0);
      if (!hold) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_count = ($urandom_range(0, 19) == 0) ? 2'd0 : 2'($urandom_range(1, FW));
        for (int l = 0; l < FW; l++) rand_lane(l);
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
